// File: rtl/serial_seq_gen_pkg.sv
// Shared constants, width derivation and FSM state type for the serial sequence generator.
package serial_seq_gen_pkg;

    localparam int MAX_LEN = 8;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int LEN_W = calc_len_w(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_seq_gen_if.sv
// Descriptor-load and serial-bit handshake bundle between a producer/consumer and the generator.
interface serial_seq_gen_if #(
    parameter int MAX_LEN = 8,
    parameter int REP_W   = 4,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               load_valid;
    logic               load_ready;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   length;
    logic [REP_W-1:0]   repeat_cnt;
    logic               new_bit;
    logic               bit_valid;
    logic               bit_ready;
    logic               last;
    logic               busy;

    modport master (
        output load_valid, pattern, length, repeat_cnt, bit_ready,
        input  load_ready, new_bit, bit_valid, last, busy
    );

    modport slave (
        input  load_valid, pattern, length, repeat_cnt, bit_ready,
        output load_ready, new_bit, bit_valid, last, busy
    );
endinterface

// File: rtl/serial_sequence_generator_piso_shift_reg.sv
// Parallel-load shift register: keeps an MSB-aligned copy of the pattern so a repetition
// can restart from the first bit without re-reading the inputs.
module piso_shift_reg #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             reload_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             serial_o
);
    logic [WIDTH-1:0] image_q;
    logic [WIDTH-1:0] image_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [LEN_W-1:0] pad_s;

    // Next-state: align bit len-1 to the MSB on load, then shift left toward it.
    always_comb begin
        image_d = image_q;
        shreg_d = shreg_q;
        pad_s   = LEN_W'(WIDTH) - len_i;
        if (clear_i) begin
            image_d = {WIDTH{1'b0}};
            shreg_d = {WIDTH{1'b0}};
        end else if (load_i) begin
            image_d = data_i << pad_s;
            shreg_d = data_i << pad_s;
        end else if (reload_i) begin
            shreg_d = image_q;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Storage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            image_q <= {WIDTH{1'b0}};
            shreg_q <= {WIDTH{1'b0}};
        end else begin
            image_q <= image_d;
            shreg_q <= shreg_d;
        end
    end

    assign serial_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_sequence_generator.sv
// Serialises a loaded pattern MSB-first (bit length-1 first), repeating it repeat_cnt+1 times
// under a valid/ready handshake; a zero-length descriptor produces a single DONE cycle.
module serial_sequence_generator #(
    parameter int MAX_LEN = serial_seq_gen_pkg::MAX_LEN,
    parameter int REP_W   = 4
) (
    input logic             clk,
    input logic             rst,
    serial_seq_gen_if.slave bus
);
    import serial_seq_gen_pkg::*;

    localparam int LW = calc_len_w(MAX_LEN);

    state_e           state_q;
    state_e           state_d;
    logic [LW-1:0]    bit_cnt_q;
    logic [LW-1:0]    bit_cnt_d;
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    len_d;
    logic [LW-1:0]    len_sat_s;
    logic             last_q;
    logic             last_d;
    logic             bit_valid_q;
    logic             busy_q;
    logic             load_ready_q;
    logic             load_s;
    logic             shift_s;
    logic             reload_s;
    logic             clear_s;
    logic             serial_s;

    // Next-state, counter and datapath-control logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        len_d     = len_q;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        reload_s  = 1'b0;
        clear_s   = 1'b0;
        len_sat_s = (bus.length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.length;
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    load_s    = 1'b1;
                    len_d     = len_sat_s;
                    bit_cnt_d = len_sat_s;
                    rep_cnt_d = bus.repeat_cnt;
                    state_d   = (len_sat_s == LW'(0)) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.bit_ready) begin
                    if (bit_cnt_q == LW'(1)) begin
                        if (rep_cnt_q == REP_W'(0)) begin
                            clear_s   = 1'b1;
                            bit_cnt_d = LW'(0);
                            state_d   = IDLE;
                        end else begin
                            // Wrap to the first bit of the next repetition with no bubble.
                            reload_s  = 1'b1;
                            rep_cnt_d = rep_cnt_q - REP_W'(1);
                            bit_cnt_d = len_q;
                        end
                    end else begin
                        shift_s   = 1'b1;
                        bit_cnt_d = bit_cnt_q - LW'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                clear_s   = 1'b1;
                bit_cnt_d = LW'(0);
                rep_cnt_d = REP_W'(0);
                state_d   = IDLE;
            end
        endcase
        last_d = (state_d == SHIFT) && (bit_cnt_d == LW'(1)) && (rep_cnt_d == REP_W'(0));
    end

    // State, counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= LW'(0);
            rep_cnt_q    <= REP_W'(0);
            len_q        <= LW'(0);
            last_q       <= 1'b0;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            len_q        <= len_d;
            last_q       <= last_d;
            bit_valid_q  <= (state_d == SHIFT);
            busy_q       <= (state_d != IDLE);
            load_ready_q <= (state_d == IDLE);
        end
    end

    piso_shift_reg #(
        .WIDTH (MAX_LEN),
        .LEN_W (LW)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_s),
        .shift_i  (shift_s),
        .reload_i (reload_s),
        .clear_i  (clear_s),
        .data_i   (bus.pattern),
        .len_i    (len_sat_s),
        .serial_o (serial_s)
    );

    // The shift register is cleared on the final transfer, so it reads 0 outside SHIFT.
    assign bus.new_bit    = serial_s;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.last       = last_q;
    assign bus.busy       = busy_q;
    assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_serial_sequence_generator.sv
// Randomised and directed bench for serial_sequence_generator against a queue-based bit-stream model.
module tb_serial_sequence_generator;
    localparam int MAX_LEN = 8;
    localparam int REP_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_seq_gen_if #(.MAX_LEN(MAX_LEN), .REP_W(REP_W)) bus();

    serial_sequence_generator #(.MAX_LEN(MAX_LEN), .REP_W(REP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the full expected bit stream of the current descriptor, front = bit on the wire.
    bit exp_q[$];
    bit done_pending = 1'b0;
    int acc_cnt = 0;
    int mdl_len;

    // Observations of the DUT for literal pins.
    bit got_q[$];
    int last_idx;
    int last_cnt;
    int stall0_cnt;
    int done_cnt;

    int ready_mode = 0;
    int stall_left = 0;
    logic [4:0] exp_v;
    logic [4:0] act_v;
    bit busy_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_busy();
        return (exp_q.size() > 0) || done_pending;
    endfunction

    function automatic logic [31:0] got_vec();
        logic [31:0] v;
        v = 32'd0;
        foreach (got_q[i]) v = {v[30:0], got_q[i]};
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            done_pending = 1'b0;
        end else if (exp_q.size() > 0) begin
            if (bus.bit_ready) void'(exp_q.pop_front());
        end else if (done_pending) begin
            done_pending = 1'b0;
        end else if (bus.load_valid) begin
            mdl_len = (int'(bus.length) > MAX_LEN) ? MAX_LEN : int'(bus.length);
            acc_cnt++;
            if (mdl_len == 0) done_pending = 1'b1;
            else
                for (int r = 0; r <= int'(bus.repeat_cnt); r++)
                    for (int i = mdl_len - 1; i >= 0; i--) exp_q.push_back(bus.pattern[i]);
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.bit_ready = 1'b1;
            1: bus.bit_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (got_q.size() == 1 && stall_left > 0 && exp_q.size() > 0) begin
                    bus.bit_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.bit_ready = 1'b1;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_v = 5'b10000;
        end else begin
            busy_e = model_busy();
            exp_v = {!busy_e, busy_e, exp_q.size() > 0,
                     (exp_q.size() > 0) ? exp_q[0] : 1'b0, exp_q.size() == 1};
        end
        act_v = {bus.load_ready, bus.busy, bus.bit_valid, bus.new_bit, bus.last};
        check("cycle_outputs", 32'(act_v), 32'(exp_v));
        if (rst && bus.bit_valid && bus.bit_ready) begin
            got_q.push_back(bus.new_bit);
            if (bus.last) begin
                last_idx = got_q.size() - 1;
                last_cnt++;
            end
        end
        if (rst && bus.bit_valid && !bus.bit_ready && !bus.new_bit) stall0_cnt++;
        if (rst && bus.busy && !bus.bit_valid) done_cnt++;
    end

    task automatic clear_obs();
        got_q.delete();
        last_idx   = -1;
        last_cnt   = 0;
        stall0_cnt = 0;
        done_cnt   = 0;
    endtask

    task automatic start(input logic [7:0] pat, input logic [LEN_W-1:0] len,
                         input logic [REP_W-1:0] rep, input bit hold);
        int acc0;
        int n;
        clear_obs();
        @(posedge clk); #2;
        bus.load_valid = 1'b1;
        bus.pattern    = pat;
        bus.length     = len;
        bus.repeat_cnt = rep;
        acc0 = acc_cnt;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (acc_cnt == acc0 && n < 100);
        if (acc_cnt == acc0) check("accept_timeout", 32'd1, 32'd0);
        bus.load_valid = hold;
        bus.pattern    = 8'($urandom);
        bus.length     = LEN_W'($urandom_range(0, 15));
        bus.repeat_cnt = REP_W'($urandom_range(0, 15));
    endtask

    task automatic finish_wait(input bit hold);
        int n;
        n = 0;
        while (model_busy() && n < 2000) begin
            bus.load_valid = hold;
            bus.pattern    = 8'($urandom);
            bus.length     = LEN_W'($urandom_range(0, 15));
            bus.repeat_cnt = REP_W'($urandom_range(0, 15));
            @(posedge clk); #2;
            n++;
        end
        bus.load_valid = 1'b0;
        if (model_busy()) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [7:0] pat, input logic [LEN_W-1:0] len,
                       input logic [REP_W-1:0] rep, input bit hold);
        start(pat, len, rep, hold);
        finish_wait(hold);
        @(posedge clk); #2;
    endtask

    initial begin
        int n;
        bus.load_valid = 1'b0;
        bus.pattern    = 8'd0;
        bus.length     = LEN_W'(0);
        bus.repeat_cnt = REP_W'(0);
        #2 rst = 1'b0;
        #1 check("reset_outputs", 32'({bus.load_ready, bus.busy, bus.bit_valid, bus.new_bit, bus.last}), 32'h10);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        ready_mode = 0;
        run(8'b0000_1011, LEN_W'(4), REP_W'(0), 1'b0);
        check("t1_bits", got_vec(), 32'b1011);
        check("t1_count", 32'(got_q.size()), 32'd4);
        check("t1_last_idx", 32'(last_idx), 32'd3);

        run(8'b0000_0110, LEN_W'(3), REP_W'(2), 1'b0);
        check("t2_bits", got_vec(), 32'b110110110);
        check("t2_last_idx", 32'(last_idx), 32'd8);
        check("t2_last_cnt", 32'(last_cnt), 32'd1);

        ready_mode = 2;
        stall_left = 3;
        run(8'b0000_1011, LEN_W'(4), REP_W'(0), 1'b0);
        check("t3_bits", got_vec(), 32'b1011);
        check("t3_stall_zero", 32'(stall0_cnt), 32'd3);
        check("t3_last_idx", 32'(last_idx), 32'd3);
        ready_mode = 0;

        run(8'hFF, LEN_W'(0), REP_W'(3), 1'b0);
        check("t4_len0_bits", 32'(got_q.size()), 32'd0);
        check("t4_len0_done", 32'(done_cnt), 32'd1);
        check("t4_len0_last", 32'(last_cnt), 32'd0);

        run(8'hA5, LEN_W'(15), REP_W'(0), 1'b0);
        check("t4_len15_bits", got_vec(), 32'hA5);
        check("t4_len15_count", 32'(got_q.size()), 32'd8);

        start(8'b0000_1011, LEN_W'(4), REP_W'(0), 1'b0);
        n = 0;
        while (got_q.size() < 2 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("t5_pre_bits", got_vec(), 32'b10);
        rst = 1'b0;
        #1 check("t5_abort_outputs", 32'({bus.load_ready, bus.busy, bus.bit_valid, bus.new_bit, bus.last}), 32'h10);
        check("t5_abort_last", 32'(last_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run(8'b0000_1001, LEN_W'(4), REP_W'(0), 1'b0);
        check("t5_after_bits", got_vec(), 32'b1001);
        check("t5_after_count", 32'(got_q.size()), 32'd4);

        n = acc_cnt;
        run(8'h0D, LEN_W'(4), REP_W'(1), 1'b1);
        check("t6_hold_bits", got_vec(), 32'b11011101);
        check("t6_hold_accepts", 32'(acc_cnt - n), 32'd1);

        for (int k = 0; k < 150; k++) begin
            ready_mode = $urandom_range(0, 1);
            run(8'($urandom), LEN_W'($urandom_range(0, 15)), REP_W'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
